// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Keeps the fetch PC, issues one word read at a time
// to instruction memory and buffers returned words, tagged with their address,
// in a DEPTH-entry prefetch FIFO whose head is offered to the decoder.
//
// Optional feature macro: FETCH_PERF_EN (adds flush_cnt_o / stall_cnt_o).
//
// Ports
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          one-cycle pulse, leaves IDLE
//   branch_taken_i   redirect request (one-cycle pulse)
//   branch_target_i  redirect byte address, low two bits ignored
//   imem_req_o       read request to instruction memory
//   imem_addr_o      word-aligned read address
//   imem_valid_i     read data valid (at least one cycle after the request)
//   imem_rdata_i     read data
//   instr_valid_o    FIFO head valid
//   instr_ready_i    decoder accepts the head
//   instr_o          FIFO head instruction
//   instr_pc_o       address of instr_o
//   busy_o           FSM not in IDLE
//   state_o          FSM state (debug)
//   flush_cnt_o      accepted redirects, saturating (FETCH_PERF_EN only)
//   stall_cnt_o      cycles with head valid but not accepted (FETCH_PERF_EN only)
//
// Handshakes: a transfer happens in a cycle where valid && ready are both 1
// at the rising edge; once valid is raised the payload holds until accepted.
// On the memory side imem_req_o/imem_addr_o stay asserted and stable from the
// cycle the request is issued until the cycle imem_valid_i returns.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_valid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              busy_o,
    output logic [1:0]        state_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       flush_cnt_o,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam int unsigned    PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   fetch_pc_q;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [PTR_W:0]      wr_ptr_q;
    logic [PTR_W:0]      rd_ptr_q;
    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [ADDR_W-1:0]   mem_pc_q   [DEPTH];
    logic [DATA_W-1:0]   last_instr_q;
    logic [ADDR_W-1:0]   last_pc_q;

    logic                empty;
    logic [PTR_W:0]      occ;
    logic [PTR_W:0]      occ_next;
    logic                redirect;
    logic                push;
    logic                pop;
    logic                outstanding;
    logic [ADDR_W-1:0]   target_al;
    logic [ADDR_W-1:0]   pc_plus4;
    logic [DATA_W-1:0]   head_instr;
    logic [ADDR_W-1:0]   head_pc;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign occ        = wr_ptr_q - rd_ptr_q;
    assign head_instr = mem_data_q[rd_ptr_q[PTR_W-1:0]];
    assign head_pc    = mem_pc_q[rd_ptr_q[PTR_W-1:0]];

    // Redirect outranks a returning word, which outranks a pop.
    assign redirect = branch_taken_i && (state_q != S_IDLE);
    assign push     = (state_q == S_WAIT) && imem_valid_i && !redirect;
    assign pop      = !empty && instr_ready_i && !redirect;
    assign occ_next = occ + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);

    // A request that memory has already seen (including one being presented in
    // FETCH this very cycle) will be answered, so it must be flushed.
    assign outstanding = (state_q == S_WAIT) || (state_q == S_FLUSH) ||
                         ((state_q == S_FETCH) && req_q);

    assign target_al = branch_target_i & ~(ADDR_W'(3));
    assign pc_plus4  = fetch_pc_q + ADDR_W'(4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            // Remember what was shown so an empty FIFO keeps presenting it.
            if (!empty) begin
                last_instr_q <= head_instr;
                last_pc_q    <= head_pc;
            end

            if (redirect) begin
                rd_ptr_q   <= wr_ptr_q;
                fetch_pc_q <= target_al;
                if (outstanding && !imem_valid_i) begin
                    // Keep the stale request on the bus until it is answered.
                    state_q <= S_FLUSH;
                end else begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= target_al;
                end
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;

                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    S_FETCH: begin
                        if (req_q) begin
                            state_q <= S_WAIT;
                        end else if (occ_next < DEPTH_C) begin
                            req_q  <= 1'b1;
                            addr_q <= fetch_pc_q;
                        end
                    end
                    S_WAIT: begin
                        if (imem_valid_i) begin
                            state_q    <= S_FETCH;
                            fetch_pc_q <= pc_plus4;
                            // The pending slot is now a real entry; only ask
                            // again if that still leaves room.
                            req_q      <= (occ_next < DEPTH_C);
                            addr_q     <= pc_plus4;
                        end
                    end
                    S_FLUSH: begin
                        if (imem_valid_i) begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q[PTR_W-1:0]] <= imem_rdata_i;
            mem_pc_q[wr_ptr_q[PTR_W-1:0]]   <= addr_q;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = !empty;
    assign instr_o       = empty ? last_instr_q : head_instr;
    assign instr_pc_o    = empty ? last_pc_q    : head_pc;
    assign busy_o        = (state_q != S_IDLE);
    assign state_o       = state_q;

`ifdef FETCH_PERF_EN
    logic [15:0] flush_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (redirect && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
            if (!empty && !instr_ready_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        busy_o;
    logic [1:0]  state_o;
`ifdef FETCH_PERF_EN
    logic [15:0] flush_cnt_o;
    logic [15:0] stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_valid_i    (imem_valid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .busy_o          (busy_o),
        .state_o         (state_o)
`ifdef FETCH_PERF_EN
        ,
        .flush_cnt_o     (flush_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];      // {pc, instr} in delivery order
    logic [31:0] req_log[$];    // addresses memory accepted
    logic [31:0] pop_log[$];    // pcs the decoder took
    logic [63:0] last_head;
    logic [31:0] model_pc;
    logic        started;
    logic        drop_pending;
    logic [15:0] flush_m, stall_m;

    // memory model
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat_min = 1, lat_max = 1;

    // stimulus knobs
    int          ready_pct = 100, branch_pct = 0;
    logic        start_req = 0, stray = 0;
    logic        arm4 = 0, hit4 = 0, arm5 = 0, hit5 = 0;
    logic        force_br = 0;
    logic [31:0] force_tgt = '0;
    int          idx5 = 0;
    logic        gap_en = 0, have_pop = 0;
    int          cycle = 0, last_pop_cycle = 0, n_pops = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [31:0] log_at(input logic [31:0] q[$], input int idx);
        if (idx < 0 || idx >= q.size()) return 32'hDEAD_BEEF;
        return q[idx];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        req_log.delete();
        pop_log.delete();
        last_head    = '0;
        model_pc     = '0;
        started      = 0;
        drop_pending = 0;
        mem_busy     = 0;
        mem_wait     = 0;
        flush_m      = '0;
        stall_m      = '0;
        have_pop     = 0;
    endtask

    task automatic check_reset_vals(input string pre);
        check_eq({pre, "_req"},    imem_req_o, 0);
        check_eq({pre, "_addr"},   imem_addr_o, 0);
        check_eq({pre, "_valid"},  instr_valid_o, 0);
        check_eq({pre, "_instr"},  instr_o, 0);
        check_eq({pre, "_pc"},     instr_pc_o, 0);
        check_eq({pre, "_busy"},   busy_o, 0);
        check_eq({pre, "_state"},  state_o, 0);
`ifdef FETCH_PERF_EN
        check_eq({pre, "_flush"},  flush_cnt_o, 0);
        check_eq({pre, "_stall"},  stall_cnt_o, 0);
`endif
    endtask

    task automatic do_reset();
        rst_ni = 0;
        start_i = 0; branch_taken_i = 0; imem_valid_i = 0; instr_ready_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_vals("rst");
        rst_ni = 1;
    endtask

    // ---------------- driver: one cycle, called at a falling edge ----------------
    task automatic step();
        logic [63:0] head;
        logic        resp, latched_now, rdy, br, st, redirect, pop;
        logic [31:0] rdata, resp_addr, tgt;
        cycle++;

        // outputs of the current cycle against the model
        check_eq("busy", busy_o, started);
        check_eq("instr_valid", instr_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            last_head = head;
        end else begin
            head = last_head;
        end
        check_eq("instr_pc", instr_pc_o, head[63:32]);
        check_eq("instr", instr_o, head[31:0]);
        if (!started) check_eq("idle_req", imem_req_o, 0);
`ifdef FETCH_PERF_EN
        check_eq("flush_cnt", flush_cnt_o, flush_m);
        check_eq("stall_cnt", stall_cnt_o, stall_m);
`endif

        // instruction memory
        resp = 0; latched_now = 0; rdata = '0; resp_addr = mem_addr;
        if (mem_busy) begin
            check_eq("req_hold", {imem_req_o, imem_addr_o}, {1'b1, mem_addr});
            mem_wait--;
            if (mem_wait == 0) begin
                resp = 1;
                rdata = $urandom;
                mem_busy = 0;
            end
        end else if (imem_req_o) begin
            check_eq("req_addr", imem_addr_o, model_pc);
            check_eq("req_room", exp_q.size() < DEPTH, 1);
            mem_busy = 1;
            mem_addr = imem_addr_o;
            mem_wait = $urandom_range(lat_max, lat_min);
            latched_now = 1;
            req_log.push_back(imem_addr_o);
        end

        // decoder / control stimulus
        rdy = ($urandom_range(99, 0) < ready_pct);
        br  = ($urandom_range(99, 0) < branch_pct);
        tgt = $urandom;
        st  = start_req;
        start_req = 0;
        if (arm4 && mem_busy && !latched_now && mem_addr == 32'h8) begin
            br = 1; tgt = 32'h103; arm4 = 0; hit4 = 1;
        end
        if (arm5 && resp && exp_q.size() == 2) begin
            rdy = 1; br = 1; tgt = 32'h200; arm5 = 0; hit5 = 1; idx5 = req_log.size();
        end
        if (force_br) begin
            br = 1; tgt = force_tgt; force_br = 0;
        end

        start_i         = st;
        instr_ready_i   = rdy;
        branch_taken_i  = br;
        branch_target_i = tgt;
        imem_valid_i    = resp | stray;
        imem_rdata_i    = resp ? rdata : $urandom;
        stray = 0;

        // reference model: what the edge is supposed to do
        redirect = br && started;
        pop = (exp_q.size() != 0) && rdy && !redirect;
        if (exp_q.size() != 0 && !rdy && stall_m != 16'hFFFF) stall_m++;
        if (redirect) begin
            if (flush_m != 16'hFFFF) flush_m++;
            exp_q.delete();
            model_pc = {tgt[31:2], 2'b00};
            drop_pending = mem_busy;
        end else begin
            if (pop) begin
                pop_log.push_back(exp_q[0][63:32]);
                if (gap_en && have_pop) check_eq("pop_gap", cycle - last_pop_cycle, 2);
                have_pop = 1;
                last_pop_cycle = cycle;
                n_pops++;
                void'(exp_q.pop_front());
            end
            if (resp) begin
                if (drop_pending) begin
                    drop_pending = 0;
                end else begin
                    exp_q.push_back({resp_addr, rdata});
                    model_pc = resp_addr + 32'd4;
                end
            end
        end
        if (st && !started) started = 1;

        @(negedge clk_i);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int wrap_idx;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // idle: no start, other inputs toggling must be ignored
        ready_pct = 50; branch_pct = 50;
        repeat (20) step();
        check_eq("idle_req_end", imem_req_o, 0);
        check_eq("idle_busy_end", busy_o, 0);

        // streaming at latency 1
        do_reset();
        ready_pct = 100; branch_pct = 0; lat_min = 1; lat_max = 1;
        gap_en = 1; start_req = 1;
        repeat (30) step();
        gap_en = 0;
        check_eq("stream_a0", log_at(req_log, 0), 32'h0);
        check_eq("stream_a1", log_at(req_log, 1), 32'h4);
        check_eq("stream_a2", log_at(req_log, 2), 32'h8);
        check_eq("stream_a3", log_at(req_log, 3), 32'hC);

        // back-pressure fills the FIFO, then drains in order
        do_reset();
        ready_pct = 0; start_req = 1;
        repeat (20) step();
        check_eq("full_nreq", req_log.size(), DEPTH);
        check_eq("full_req", imem_req_o, 0);
        ready_pct = 100;
        repeat (20) step();
        check_eq("drain_p0", log_at(pop_log, 0), 32'h0);
        check_eq("drain_p1", log_at(pop_log, 1), 32'h4);
        check_eq("drain_p2", log_at(pop_log, 2), 32'h8);
        check_eq("drain_p3", log_at(pop_log, 3), 32'hC);
        check_eq("resume_addr", log_at(req_log, 4), 32'h10);

        // redirect while waiting on 0x8 with latency 3
        do_reset();
        ready_pct = 0; lat_min = 3; lat_max = 3; arm4 = 1; hit4 = 0; start_req = 1;
        for (int i = 0; i < 60 && !hit4; i++) step();
        check_eq("br_wait_hit", hit4, 1);
        arm4 = 0;
        check_eq("br_wait_empty", instr_valid_o, 0);
        ready_pct = 100;
        repeat (20) step();
        check_eq("br_wait_next_req", log_at(req_log, 3), 32'h100);
        check_eq("br_wait_first_pc", log_at(pop_log, 0), 32'h100);

        // redirect coinciding with a response and a pop, two entries held
        do_reset();
        ready_pct = 0; lat_min = 1; lat_max = 1; arm5 = 1; hit5 = 0; start_req = 1;
        for (int i = 0; i < 60 && !hit5; i++) step();
        check_eq("br_coll_hit", hit5, 1);
        arm5 = 0;
        check_eq("br_coll_empty", instr_valid_o, 0);
        ready_pct = 100;
        repeat (10) step();
        check_eq("br_coll_next_req", log_at(req_log, idx5), 32'h200);

        // address wrap at the top of memory
        do_reset();
        start_req = 1;
        repeat (3) step();
        force_tgt = 32'hFFFF_FFFE; force_br = 1;
        repeat (12) step();
        wrap_idx = -10;
        for (int i = 0; i < req_log.size(); i++)
            if (req_log[i] == 32'hFFFF_FFFC && wrap_idx < 0) wrap_idx = i;
        check_eq("wrap_next", log_at(req_log, wrap_idx + 1), 32'h0);

        // asynchronous reset while a read is outstanding
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !mem_busy; i++) step();
        check_eq("midwait_found", mem_busy, 1);
        #1 rst_ni = 0;
        #1 check_reset_vals("async");
        @(negedge clk_i);
        start_i = 0; branch_taken_i = 0; imem_valid_i = 0;
        model_reset();
        @(negedge clk_i);
        rst_ni = 1;
        // the abandoned read answering in IDLE is ignored
        stray = 1;
        repeat (4) step();
        check_eq("stray_valid", instr_valid_o, 0);

`ifdef FETCH_PERF_EN
        // 5 stall cycles, then 3 redirects
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 0; branch_pct = 0; start_req = 1;
        for (int i = 0; i < 20 && exp_q.size() == 0; i++) step();
        repeat (5) step();
        ready_pct = 100;
        for (int i = 0; i < 3; i++) begin
            force_tgt = 32'h40 * i; force_br = 1;
            step();
        end
        check_eq("perf_flush", flush_cnt_o, 3);
        check_eq("perf_stall", stall_cnt_o, 5);
`endif

        // randomized traffic against the model
        do_reset();
        lat_min = 1; lat_max = 4; ready_pct = 70; branch_pct = 4; start_req = 1;
        repeat (3000) step();
        check_eq("progress", n_pops > 100, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
